sdram_cmd_responder: RTL and testbench

//  Synthesizable single-data-rate SDRAM device model on the target side of the DDR command bus.

---
 rtl/sdram_cmd_responder.sv | 254 +++++++++++++++++++++++++
 tb/tb_sdram_cmd_responder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sdram_cmd_responder.sv
// SDRAM device model on the target side of the DDR command bus: decodes commands, tracks
// bank/row state, keeps written data in a small RAM, returns read bursts and flags protocol errors.
module sdram_cmd_responder #(
  parameter int unsigned CasLatency  = 2,
  parameter int unsigned BurstLength = 2,
  parameter int unsigned TRcd        = 2,
  parameter int unsigned MemAddrBits = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ddr_cke,
  input  logic        ddr_csn,
  input  logic        ddr_rasn,
  input  logic        ddr_casn,
  input  logic        ddr_wen,
  input  logic [1:0]  ddr_ba,
  input  logic [12:0] ddr_addr,
  input  logic [1:0]  ddr_dm,
  input  logic [15:0] dq_i,
  output logic [15:0] dq_o,
  output logic        dq_oe,
  output logic        err,
  output logic [3:0]  err_code
);

  localparam int unsigned LgBl     = $clog2(BurstLength);
  localparam int unsigned StepW    = $clog2(CasLatency + BurstLength);
  localparam int unsigned TrcdW    = (TRcd > 1) ? $clog2(TRcd) : 1;
  localparam int unsigned WordW    = MemAddrBits;
  localparam int unsigned HiW      = WordW - LgBl;
  localparam int unsigned NumWords = 1 << WordW;

  localparam logic [StepW-1:0] WrLast   = StepW'(BurstLength - 1);
  localparam logic [StepW-1:0] RdFirst  = StepW'(CasLatency - 1);
  localparam logic [StepW-1:0] RdLast   = StepW'(CasLatency + BurstLength - 2);
  localparam logic [TrcdW-1:0] TrcdLoad = TrcdW'(TRcd - 1);

  localparam logic [2:0] CmdNop   = 3'b111;
  localparam logic [2:0] CmdAct   = 3'b011;
  localparam logic [2:0] CmdRead  = 3'b101;
  localparam logic [2:0] CmdWrite = 3'b100;
  localparam logic [2:0] CmdPre   = 3'b010;
  localparam logic [2:0] CmdRef   = 3'b001;
  localparam logic [2:0] CmdLmr   = 3'b000;
  localparam logic [2:0] CmdBst   = 3'b110;

  localparam logic [3:0] ErrNone       = 4'd0;
  localparam logic [3:0] ErrActOpen    = 4'd1;
  localparam logic [3:0] ErrBankClosed = 4'd2;
  localparam logic [3:0] ErrTrcd       = 4'd3;
  localparam logic [3:0] ErrBanksOpen  = 4'd4;
  localparam logic [3:0] ErrUninit     = 4'd5;
  localparam logic [3:0] ErrBurst      = 4'd6;
  localparam logic [3:0] ErrMode       = 4'd7;

  typedef enum logic {
    ST_UNINIT = 1'b0,
    ST_READY  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [3:0]       r_open;
  logic [12:0]      r_row  [4];
  logic [TrcdW-1:0] r_trcd [4];

  logic             r_busy;
  logic             r_is_rd;
  logic             r_ap;
  logic [1:0]       r_bank;
  logic [StepW-1:0] r_step;
  logic [HiW-1:0]   r_base_hi;
  logic [LgBl-1:0]  r_start;

  logic [15:0]      r_mem [NumWords];
  logic [15:0]      r_dq;
  logic             r_dq_oe;
  logic             r_err;
  logic [3:0]       r_err_code;

  logic             w_cmd_en;
  logic [2:0]       w_cmd;
  logic             w_lmr_match;
  logic             w_in_flight;
  logic [3:0]       w_code;
  logic             w_ok;
  logic             w_act;
  logic             w_pre;
  logic             w_rd_go;
  logic             w_wr_go;
  logic             w_lmr_ok;
  logic [WordW-1:0] w_cmd_word;
  logic [LgBl-1:0]  w_burst_col;
  logic [WordW-1:0] w_burst_word;
  logic [WordW-1:0] w_mem_addr;
  logic             w_burst_end;
  logic             w_fetch;
  logic             w_wbeat;
  logic             w_mem_we;

  // Command decode; deselected or clock-disabled cycles look like NOP
  assign w_cmd_en    = ddr_cke & ~ddr_csn;
  assign w_cmd       = w_cmd_en ? {ddr_rasn, ddr_casn, ddr_wen} : CmdNop;
  assign w_lmr_match = (ddr_addr[6:4] == 3'(CasLatency)) && (ddr_addr[2:0] == 3'(LgBl));
  assign w_in_flight = r_busy | r_dq_oe;
  assign w_cmd_word  = WordW'({ddr_ba, r_row[ddr_ba], ddr_addr[9:0]});

  // Sequential wrap inside the burst: only the low lg(BL) column bits advance
  assign w_burst_col  = r_start + (r_is_rd ? LgBl'(r_step - RdFirst) : LgBl'(r_step));
  assign w_burst_word = {r_base_hi, w_burst_col};
  assign w_fetch      = r_busy && r_is_rd && (r_step >= RdFirst);
  assign w_wbeat      = r_busy && !r_is_rd;
  assign w_burst_end  = r_busy && (r_step == (r_is_rd ? RdLast : WrLast));
  assign w_mem_we     = reset && (w_wr_go || w_wbeat);
  assign w_mem_addr   = w_wr_go ? w_cmd_word : w_burst_word;

  // State register
  always_ff @(posedge clock) begin
    if (!reset) r_state <= ST_UNINIT;
    else        r_state <= w_state_nxt;
  end

  // Next state: leave UNINIT on the first accepted mode-register load
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_UNINIT: if (w_lmr_ok) w_state_nxt = ST_READY;
      ST_READY:  w_state_nxt = ST_READY;
      default:   w_state_nxt = ST_UNINIT;
    endcase
  end

  // Legality checks in ascending code order so the lowest code wins; accepted-command strobes
  always_comb begin
    w_code = ErrNone;
    if ((r_state == ST_UNINIT) && (w_cmd != CmdNop) && (w_cmd != CmdPre) && (w_cmd != CmdLmr)) begin
      w_code = ErrUninit;
    end else begin
      case (w_cmd)
        CmdAct: if (r_open[ddr_ba]) w_code = ErrActOpen;
        CmdRead, CmdWrite: begin
          if (!r_open[ddr_ba])              w_code = ErrBankClosed;
          else if (r_trcd[ddr_ba] != '0)    w_code = ErrTrcd;
          else if (w_in_flight)             w_code = ErrBurst;
        end
        CmdRef: if (|r_open) w_code = ErrBanksOpen;
        CmdLmr: begin
          if (|r_open)           w_code = ErrBanksOpen;
          else if (!w_lmr_match) w_code = ErrMode;
        end
        CmdBst:  w_code = ErrBurst;
        default: w_code = ErrNone;
      endcase
    end
    w_ok     = (w_code == ErrNone);
    w_act    = w_ok && (w_cmd == CmdAct);
    w_pre    = w_ok && (w_cmd == CmdPre);
    w_rd_go  = w_ok && (w_cmd == CmdRead);
    w_wr_go  = w_ok && (w_cmd == CmdWrite);
    w_lmr_ok = w_ok && (w_cmd == CmdLmr);
  end

  // Bank open/row/tRCD tracking; auto-precharge applied before this cycle's command
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_open <= '0;
      for (int b = 0; b < 4; b++) begin
        r_row[b]  <= '0;
        r_trcd[b] <= '0;
      end
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (ddr_cke && (r_trcd[b] != '0)) r_trcd[b] <= r_trcd[b] - TrcdW'(1);
      end
      if (w_burst_end && r_ap) r_open[r_bank] <= 1'b0;
      if (w_act) begin
        r_open[ddr_ba] <= 1'b1;
        r_row[ddr_ba]  <= ddr_addr;
        r_trcd[ddr_ba] <= TrcdLoad;
      end
      if (w_pre) begin
        if (ddr_addr[10]) r_open <= '0;
        else              r_open[ddr_ba] <= 1'b0;
      end
    end
  end

  // Burst sequencer; step counts cycles after the command cycle
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_busy    <= 1'b0;
      r_is_rd   <= 1'b0;
      r_ap      <= 1'b0;
      r_bank    <= '0;
      r_step    <= '0;
      r_base_hi <= '0;
      r_start   <= '0;
    end else begin
      if (r_busy) begin
        r_step <= r_step + StepW'(1);
        if (w_burst_end) r_busy <= 1'b0;
      end
      if (w_rd_go || w_wr_go) begin
        r_busy    <= 1'b1;
        r_is_rd   <= w_rd_go;
        r_ap      <= ddr_addr[10];
        r_bank    <= ddr_ba;
        r_step    <= StepW'(1);
        r_base_hi <= w_cmd_word[WordW-1:LgBl];
        r_start   <= ddr_addr[LgBl-1:0];
      end
    end
  end

  // Byte-masked storage; contents survive reset
  always_ff @(posedge clock) begin
    if (w_mem_we) begin
      if (!ddr_dm[0]) r_mem[w_mem_addr][7:0]  <= dq_i[7:0];
      if (!ddr_dm[1]) r_mem[w_mem_addr][15:8] <= dq_i[15:8];
    end
  end

  // Read data path: fetch one cycle ahead so beat0 appears CL cycles after the command
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_dq    <= '0;
      r_dq_oe <= 1'b0;
    end else if (w_fetch) begin
      r_dq    <= r_mem[w_burst_word];
      r_dq_oe <= 1'b1;
    end else begin
      r_dq    <= '0;
      r_dq_oe <= 1'b0;
    end
  end

  // First-error capture, sticky until reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_err      <= 1'b0;
      r_err_code <= ErrNone;
    end else if (!r_err && !w_ok) begin
      r_err      <= 1'b1;
      r_err_code <= w_code;
    end
  end

  assign dq_o     = r_dq;
  assign dq_oe    = r_dq_oe;
  assign err      = r_err;
  assign err_code = r_err_code;

endmodule

// File: tb/tb_sdram_cmd_responder.sv
// Directed bench for sdram_cmd_responder: a BL2 instance and a BL4 instance share one
// command bus; sel4 steers the clock enable so only one of them decodes at a time.
module tb_sdram_cmd_responder;

  localparam logic [2:0] CNOP = 3'b111;
  localparam logic [2:0] CACT = 3'b011;
  localparam logic [2:0] CRD  = 3'b101;
  localparam logic [2:0] CWR  = 3'b100;
  localparam logic [2:0] CLMR = 3'b000;
  localparam logic [2:0] CBST = 3'b110;

  logic        clock;
  logic        reset;
  logic        ddr_cke;
  logic        sel4;
  logic        ddr_csn;
  logic        ddr_rasn;
  logic        ddr_casn;
  logic        ddr_wen;
  logic [1:0]  ddr_ba;
  logic [12:0] ddr_addr;
  logic [1:0]  ddr_dm;
  logic [15:0] dq_i;

  logic [15:0] dq_o;
  logic        dq_oe;
  logic        err;
  logic [3:0]  err_code;
  logic [15:0] dq_o4;
  logic        dq_oe4;
  logic        err4;
  logic [3:0]  err_code4;

  int checks = 0;
  int errors = 0;

  sdram_cmd_responder #(.CasLatency(2), .BurstLength(2), .TRcd(2), .MemAddrBits(8)) dut (
    .clock(clock), .reset(reset), .ddr_cke(ddr_cke & ~sel4), .ddr_csn(ddr_csn),
    .ddr_rasn(ddr_rasn), .ddr_casn(ddr_casn), .ddr_wen(ddr_wen), .ddr_ba(ddr_ba),
    .ddr_addr(ddr_addr), .ddr_dm(ddr_dm), .dq_i(dq_i),
    .dq_o(dq_o), .dq_oe(dq_oe), .err(err), .err_code(err_code)
  );

  sdram_cmd_responder #(.CasLatency(2), .BurstLength(4), .TRcd(2), .MemAddrBits(8)) dut4 (
    .clock(clock), .reset(reset), .ddr_cke(ddr_cke & sel4), .ddr_csn(ddr_csn),
    .ddr_rasn(ddr_rasn), .ddr_casn(ddr_casn), .ddr_wen(ddr_wen), .ddr_ba(ddr_ba),
    .ddr_addr(ddr_addr), .ddr_dm(ddr_dm), .dq_i(dq_i),
    .dq_o(dq_o4), .dq_oe(dq_oe4), .err(err4), .err_code(err_code4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Present one command for one cycle; returns 1 time unit after the sampling edge
  task automatic cmd(input logic [2:0] c, input logic [1:0] ba, input logic [12:0] addr,
                     input logic [15:0] d, input logic [1:0] dm);
    ddr_csn = 1'b0;
    {ddr_rasn, ddr_casn, ddr_wen} = c;
    ddr_ba   = ba;
    ddr_addr = addr;
    dq_i     = d;
    ddr_dm   = dm;
    @(posedge clock);
    #1;
  endtask

  task automatic nop(input logic [15:0] d, input logic [1:0] dm);
    cmd(CNOP, 2'd0, 13'h0, d, dm);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    nop(16'h0, 2'b00);
    nop(16'h0, 2'b00);
    reset = 1'b1;
  endtask

  initial begin
    reset    = 1'b0;
    ddr_cke  = 1'b1;
    sel4     = 1'b0;
    ddr_csn  = 1'b1;
    ddr_rasn = 1'b1;
    ddr_casn = 1'b1;
    ddr_wen  = 1'b1;
    ddr_ba   = '0;
    ddr_addr = '0;
    ddr_dm   = '0;
    dq_i     = '0;

    // 1: reset values, idle, then READ before LMR
    nop(16'h0, 2'b00);
    nop(16'h0, 2'b00);
    check("rst_dq_o", dq_o, 16'h0);
    check("rst_dq_oe", 16'(dq_oe), 16'h0);
    check("rst_err", 16'(err), 16'h0);
    check("rst_err_code", 16'(err_code), 16'h0);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) nop(16'h0, 2'b00);
    check("idle_dq_oe", 16'(dq_oe), 16'h0);
    check("idle_err", 16'(err), 16'h0);
    cmd(CRD, 2'd0, 13'h000, 16'h0, 2'b00);
    check("uninit_rd_err", 16'(err), 16'h1);
    check("uninit_rd_code", 16'(err_code), 16'h5);
    nop(16'h0, 2'b00);
    check("uninit_rd_no_oe", 16'(dq_oe), 16'h0);

    // 2: BL2 write then read, beat0 at t+2, oe for exactly two cycles
    do_reset();
    cmd(CLMR, 2'd0, 13'h021, 16'h0, 2'b00);
    cmd(CACT, 2'd1, 13'h012, 16'h0, 2'b00);
    nop(16'h0, 2'b00);
    cmd(CWR, 2'd1, 13'h004, 16'hA5A5, 2'b00);
    nop(16'h5A5A, 2'b00);
    cmd(CRD, 2'd1, 13'h004, 16'h0, 2'b00);
    check("rd_t1_oe", 16'(dq_oe), 16'h0);
    nop(16'h0, 2'b00);
    check("rd_b0_oe", 16'(dq_oe), 16'h1);
    check("rd_b0_dq", dq_o, 16'hA5A5);
    nop(16'h0, 2'b00);
    check("rd_b1_oe", 16'(dq_oe), 16'h1);
    check("rd_b1_dq", dq_o, 16'h5A5A);
    nop(16'h0, 2'b00);
    check("rd_end_oe", 16'(dq_oe), 16'h0);
    check("rd_end_dq", dq_o, 16'h0);
    check("bl2_no_err", 16'(err), 16'h0);

    // 3: low byte masked on overwrite of 1234
    cmd(CWR, 2'd1, 13'h010, 16'h1234, 2'b00);
    nop(16'h0000, 2'b00);
    cmd(CWR, 2'd1, 13'h010, 16'hFFFF, 2'b01);
    nop(16'hFFFF, 2'b00);
    cmd(CRD, 2'd1, 13'h010, 16'h0, 2'b00);
    nop(16'h0, 2'b00);
    check("mask_b0", dq_o, 16'hFF34);
    nop(16'h0, 2'b00);
    check("mask_b1", dq_o, 16'hFFFF);
    check("mask_no_err", 16'(err), 16'h0);

    // 4: BL4 wrap order, READ col 6 -> cols 6,7,4,5
    sel4 = 1'b1;
    do_reset();
    cmd(CLMR, 2'd0, 13'h022, 16'h0, 2'b00);
    cmd(CACT, 2'd0, 13'h000, 16'h0, 2'b00);
    nop(16'h0, 2'b00);
    cmd(CWR, 2'd0, 13'h004, 16'h1111, 2'b00);
    nop(16'h2222, 2'b00);
    nop(16'h3333, 2'b00);
    nop(16'h4444, 2'b00);
    cmd(CRD, 2'd0, 13'h006, 16'h0, 2'b00);
    nop(16'h0, 2'b00);
    check("bl4_b0", dq_o4, 16'h3333);
    nop(16'h0, 2'b00);
    check("bl4_b1", dq_o4, 16'h4444);
    nop(16'h0, 2'b00);
    check("bl4_b2", dq_o4, 16'h1111);
    nop(16'h0, 2'b00);
    check("bl4_b3", dq_o4, 16'h2222);
    check("bl4_b3_oe", 16'(dq_oe4), 16'h1);
    nop(16'h0, 2'b00);
    check("bl4_end_oe", 16'(dq_oe4), 16'h0);
    check("bl4_no_err", 16'(err4), 16'h0);
    sel4 = 1'b0;

    // 5: tRCD violation, double ACT with sticky first code, bad mode register
    do_reset();
    cmd(CLMR, 2'd0, 13'h021, 16'h0, 2'b00);
    cmd(CACT, 2'd2, 13'h005, 16'h0, 2'b00);
    cmd(CRD, 2'd2, 13'h000, 16'h0, 2'b00);
    check("trcd_err", 16'(err), 16'h1);
    check("trcd_code", 16'(err_code), 16'h3);
    do_reset();
    cmd(CLMR, 2'd0, 13'h021, 16'h0, 2'b00);
    cmd(CACT, 2'd3, 13'h001, 16'h0, 2'b00);
    nop(16'h0, 2'b00);
    check("act1_no_err", 16'(err), 16'h0);
    cmd(CACT, 2'd3, 13'h002, 16'h0, 2'b00);
    check("act2_code", 16'(err_code), 16'h1);
    cmd(CBST, 2'd0, 13'h000, 16'h0, 2'b00);
    check("sticky_code", 16'(err_code), 16'h1);
    do_reset();
    cmd(CLMR, 2'd0, 13'h031, 16'h0, 2'b00);
    check("lmr_bad_code", 16'(err_code), 16'h7);

    // 6: reset mid read burst, then READ before LMR
    do_reset();
    cmd(CLMR, 2'd0, 13'h021, 16'h0, 2'b00);
    cmd(CACT, 2'd0, 13'h000, 16'h0, 2'b00);
    nop(16'h0, 2'b00);
    cmd(CRD, 2'd0, 13'h000, 16'h0, 2'b00);
    nop(16'h0, 2'b00);
    check("mid_burst_oe", 16'(dq_oe), 16'h1);
    reset = 1'b0;
    nop(16'h0, 2'b00);
    check("abort_oe", 16'(dq_oe), 16'h0);
    check("abort_dq", dq_o, 16'h0);
    reset = 1'b1;
    cmd(CRD, 2'd0, 13'h000, 16'h0, 2'b00);
    check("post_rst_code", 16'(err_code), 16'h5);
    nop(16'h0, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
